// File: rtl/fpu_cvt_arb.sv
`default_nettype none
// ============================================================================
// Module   : fpu_cvt_arb
// Purpose  : Round-robin arbiter sharing one single-precision int-to-float
//            converter (fpu_sp_i2f) among NREQ requesters. One conversion is
//            in flight at a time; a watchdog aborts a conversion that never
//            completes and returns a quiet NaN instead.
// Ports    : clk, rst_n               clock, async active-low reset
//            req_val/req_data/req_ack per-requester request handshake
//            rsp_val/rsp_data         one-hot response strobe + shared result
//            cvt_din/cvt_dval         operand + start pulse to the converter
//            cvt_result/cvt_rdy       result + done pulse from the converter
//            busy                     arbiter not idle
//            err                      one-cycle pulse on watchdog abort
// Revision : 1.0 - initial release
// ============================================================================
module fpu_cvt_arb #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 63
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_val,
   input  logic [32*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ack,
   output logic [NREQ-1:0]      rsp_val,
   output logic [31:0]          rsp_data,
   output logic [31:0]          cvt_din,
   output logic                 cvt_dval,
   input  logic [31:0]          cvt_result,
   input  logic                 cvt_rdy,
   output logic                 busy,
   output logic                 err
);

   localparam int c_ptr_w = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int c_cnt_w = $clog2(TIMEOUT + 1);

   // WAIT aborts one cycle after cnt has reached TIMEOUT-1, which places the
   // NaN response TIMEOUT+1 cycles after the converter start pulse.
   localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(TIMEOUT);
   localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(TIMEOUT - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
   localparam logic [c_ptr_w-1:0] c_ptr_init  = c_ptr_w'(NREQ - 1);
   localparam logic [NREQ-1:0]    c_req_one   = NREQ'(1);
   localparam logic [31:0]        c_qnan      = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
   logic [c_ptr_w-1:0]   r_last, w_last_nxt;
   logic [NREQ-1:0]      r_req_ack, w_req_ack_nxt;
   logic [NREQ-1:0]      r_rsp_val, w_rsp_val_nxt;
   logic [31:0]          r_rsp_data, w_rsp_data_nxt;
   logic [31:0]          r_cvt_din, w_cvt_din_nxt;
   logic                 r_cvt_dval, w_cvt_dval_nxt;
   logic                 r_err, w_err_nxt;
   logic                 r_busy;

   logic                 w_found;
   logic [c_ptr_w-1:0]   w_grant;
   logic [c_ptr_w-1:0]   w_cand;

   // (base + k) mod NREQ for k in 1..NREQ; works for non-power-of-two NREQ.
   function automatic logic [c_ptr_w-1:0] wrap_add(input logic [c_ptr_w-1:0] base,
                                                   input int k);
      int s;
      s = int'(base) + k;
      if (s >= NREQ) s = s - NREQ;
      return c_ptr_w'(s);
   endfunction

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      w_found = 1'b0;
      w_grant = r_last;
      w_cand  = r_last;
      for (int k = 1; k <= NREQ; k++) begin
         w_cand = wrap_add(r_last, k);
         if (!w_found && req_val[w_cand]) begin
            w_found = 1'b1;
            w_grant = w_cand;
         end
      end
   end

   // Next-state and registered-output logic. r_last doubles as the index of
   // the requester owning the in-flight conversion.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_last_nxt     = r_last;
      w_req_ack_nxt  = '0;
      w_rsp_val_nxt  = '0;
      w_cvt_dval_nxt = 1'b0;
      w_err_nxt      = 1'b0;
      w_rsp_data_nxt = r_rsp_data;
      w_cvt_din_nxt  = r_cvt_din;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_cvt_din_nxt  = req_data[{w_grant, 5'b0} +: 32];
               w_cvt_dval_nxt = 1'b1;
               w_req_ack_nxt  = c_req_one << w_grant;
               w_last_nxt     = w_grant;
               w_cnt_nxt      = '0;
               w_state_nxt    = S_WAIT;
            end
         end
         S_WAIT: begin
            w_cnt_nxt = r_cnt + c_cnt_one;
            if (cvt_rdy) begin
               // A result arriving on the abort cycle still wins.
               w_rsp_data_nxt = cvt_result;
               w_rsp_val_nxt  = c_req_one << r_last;
               w_state_nxt    = S_IDLE;
            end else if (r_cnt == c_wait_last) begin
               w_rsp_data_nxt = c_qnan;
               w_rsp_val_nxt  = c_req_one << r_last;
               w_err_nxt      = 1'b1;
               w_cnt_nxt      = '0;
               w_state_nxt    = S_HOLD;
            end
         end
         S_HOLD: begin
            // No new grant here: a late rdy from the aborted conversion must
            // not be attributed to a fresh request. The late result is dropped.
            w_cnt_nxt = r_cnt + c_cnt_one;
            if (cvt_rdy || (r_cnt == c_hold_last)) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_last     <= c_ptr_init;
         r_req_ack  <= '0;
         r_rsp_val  <= '0;
         r_rsp_data <= '0;
         r_cvt_din  <= '0;
         r_cvt_dval <= 1'b0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_last     <= w_last_nxt;
         r_req_ack  <= w_req_ack_nxt;
         r_rsp_val  <= w_rsp_val_nxt;
         r_rsp_data <= w_rsp_data_nxt;
         r_cvt_din  <= w_cvt_din_nxt;
         r_cvt_dval <= w_cvt_dval_nxt;
         r_err      <= w_err_nxt;
         r_busy     <= (w_state_nxt != S_IDLE);
      end
   end

   assign req_ack  = r_req_ack;
   assign rsp_val  = r_rsp_val;
   assign rsp_data = r_rsp_data;
   assign cvt_din  = r_cvt_din;
   assign cvt_dval = r_cvt_dval;
   assign err      = r_err;
   assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fpu_cvt_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_cvt_arb
// Purpose  : Self-checking bench for fpu_cvt_arb. Provides requester agents,
//            a behavioural converter with random 5..38 cycle latency, and a
//            transaction-level model of grant order, response timing,
//            watchdog abort and hold behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_cvt_arb;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 63;

   logic                clk;
   logic                rst_n;
   logic [NREQ-1:0]     req_val;
   logic [32*NREQ-1:0]  req_data;
   logic [NREQ-1:0]     req_ack;
   logic [NREQ-1:0]     rsp_val;
   logic [31:0]         rsp_data;
   logic [31:0]         cvt_din;
   logic                cvt_dval;
   logic [31:0]         cvt_result;
   logic                cvt_rdy;
   logic                busy;
   logic                err;

   fpu_cvt_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_val    (req_val),
      .req_data   (req_data),
      .req_ack    (req_ack),
      .rsp_val    (rsp_val),
      .rsp_data   (rsp_data),
      .cvt_din    (cvt_din),
      .cvt_dval   (cvt_dval),
      .cvt_result (cvt_result),
      .cvt_rdy    (cvt_rdy),
      .busy       (busy),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // requester agents
   logic [31:0]     rq [NREQ][$];
   logic [NREQ-1:0] drop;

   // transaction-level model
   bit              m_idle, m_wait, m_hold;
   int              m_g, m_last, m_dval_cyc, m_hold_start;
   logic [31:0]     m_op;
   logic [NREQ-1:0] p_req;
   logic [32*NREQ-1:0] p_data;
   bit              p_rdy;

   // converter model
   bit              conv_dead, conv_pend, inj;
   int              conv_cnt;
   logic [31:0]     conv_cap;

   // observation logs
   int              grant_log[$];
   logic [31:0]     last_rsp_data;
   int              last_rsp_idx;
   int              n_ack, n_dval, n_rsp, n_err;
   int              dval_cyc_obs, err_cyc_obs;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference int32 -> IEEE-754 single, round to nearest even.
   function automatic logic [31:0] i2f(input logic [31:0] x);
      logic [63:0] m, mant, rem, half;
      int e, sh;
      if (x == 32'd0) return 32'd0;
      m = x[31] ? ((64'd1 << 32) - {32'd0, x}) : {32'd0, x};
      e = 0;
      for (int b = 0; b < 33; b++) if (m[b]) e = b;
      if (e <= 23) begin
         mant = m << (23 - e);
      end else begin
         sh   = e - 23;
         mant = m >> sh;
         rem  = m & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
         if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            e    = e + 1;
         end
      end
      return {x[31], 8'(e + 127), mant[22:0]};
   endfunction

   function automatic int winner(input logic [NREQ-1:0] r, input int last);
      for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
      return -1;
   endfunction

   function automatic int idx_of(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic bit queues_empty();
      for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // One cycle: check this cycle's outputs against the model, then drive the
   // converter and requester inputs for this cycle.
   task automatic tick();
      logic [NREQ-1:0] e_ack, e_rsp;
      logic            e_dval, e_err;
      logic [31:0]     e_din, e_data;
      int              w;
      @(negedge clk);
      cyc++;
      e_ack = '0; e_rsp = '0; e_dval = 1'b0; e_err = 1'b0; e_din = '0; e_data = '0;
      if (m_idle && (p_req != '0)) begin
         w          = winner(p_req, m_last);
         e_ack      = NREQ'(1) << w;
         e_dval     = 1'b1;
         e_din      = p_data[32*w +: 32];
         m_idle     = 1'b0;
         m_wait     = 1'b1;
         m_g        = w;
         m_last     = w;
         m_op       = e_din;
         m_dval_cyc = cyc;
      end else if (m_wait) begin
         if (p_rdy) begin
            e_rsp  = NREQ'(1) << m_g;
            e_data = i2f(m_op);
            m_wait = 1'b0;
            m_idle = 1'b1;
         end else if (cyc == m_dval_cyc + TIMEOUT + 1) begin
            e_rsp        = NREQ'(1) << m_g;
            e_data       = 32'h7FC0_0000;
            e_err        = 1'b1;
            m_wait       = 1'b0;
            m_hold       = 1'b1;
            m_hold_start = cyc;
         end
      end else if (m_hold) begin
         if (p_rdy || (cyc == m_hold_start + TIMEOUT)) begin
            m_hold = 1'b0;
            m_idle = 1'b1;
         end
      end

      chk("req_ack", 32'(req_ack), 32'(e_ack));
      chk("cvt_dval", 32'(cvt_dval), 32'(e_dval));
      if (e_dval) chk("cvt_din", cvt_din, e_din);
      chk("rsp_val", 32'(rsp_val), 32'(e_rsp));
      if (e_rsp != '0) chk("rsp_data", rsp_data, e_data);
      chk("err", 32'(err), 32'(e_err));
      chk("busy", 32'(busy), 32'(!m_idle));

      if (req_ack != '0) begin n_ack++; grant_log.push_back(idx_of(req_ack)); end
      if (cvt_dval) begin n_dval++; dval_cyc_obs = cyc; end
      if (rsp_val != '0) begin n_rsp++; last_rsp_data = rsp_data; last_rsp_idx = idx_of(rsp_val); end
      if (err) begin n_err++; err_cyc_obs = cyc; end

      // converter
      cvt_rdy    = 1'b0;
      cvt_result = $urandom;
      if (conv_pend) begin
         conv_cnt--;
         if (conv_cnt == 0) begin
            conv_pend  = 1'b0;
            cvt_rdy    = 1'b1;
            cvt_result = i2f(conv_cap);
         end
      end
      if (inj) begin
         cvt_rdy = 1'b1;
         inj     = 1'b0;
      end
      if (cvt_dval && !conv_dead) begin
         conv_pend = 1'b1;
         conv_cnt  = int'($urandom_range(38, 5));
         conv_cap  = cvt_din;
      end
      p_rdy = cvt_rdy;

      // requesters: hold until ack, drop the cycle after, reissue later
      for (int i = 0; i < NREQ; i++) begin
         if (drop[i]) begin
            req_val[i] = 1'b0;
            drop[i]    = 1'b0;
         end else if (req_val[i] && req_ack[i]) begin
            drop[i] = 1'b1;
            void'(rq[i].pop_front());
         end else if (!req_val[i] && rq[i].size() != 0) begin
            req_val[i]           = 1'b1;
            req_data[32*i +: 32] = rq[i][0];
         end
      end
      p_req  = req_val;
      p_data = req_data;
   endtask

   task automatic run_quiet(input int maxc);
      int n;
      n = 0;
      while (!(m_idle && req_val == '0 && drop == '0 && queues_empty() && !conv_pend) && n < maxc) begin
         tick();
         n++;
      end
      chk("quiet_bound", 32'(n < maxc), 32'd1);
      tick();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_req_ack", 32'(req_ack), 32'd0);
      chk("rst_rsp_val", 32'(rsp_val), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_cvt_din", cvt_din, 32'd0);
      chk("rst_cvt_dval", 32'(cvt_dval), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      req_val = '0; drop = '0;
      cvt_rdy = 1'b0; conv_pend = 1'b0; inj = 1'b0;
      m_idle = 1'b1; m_wait = 1'b0; m_hold = 1'b0; m_last = NREQ - 1;
      p_req = '0; p_rdy = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] tv [4];
      logic [31:0] te [4];
      int          base, nb, n;
      tv = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
      te = '{32'h0000_0000, 32'hBF80_0000, 32'h4F00_0000, 32'hCF00_0000};
      rst_n = 1'b0; req_val = '0; req_data = '0; cvt_rdy = 1'b0; cvt_result = '0;
      drop = '0; conv_dead = 1'b0; conv_pend = 1'b0; inj = 1'b0; conv_cnt = 0; conv_cap = '0;
      m_idle = 1'b1; m_wait = 1'b0; m_hold = 1'b0; m_last = NREQ - 1; m_g = 0;
      m_dval_cyc = 0; m_hold_start = 0; m_op = '0; p_req = '0; p_data = '0; p_rdy = 1'b0;
      last_rsp_data = '0; last_rsp_idx = -1; n_ack = 0; n_dval = 0; n_rsp = 0; n_err = 0;
      dval_cyc_obs = 0; err_cyc_obs = 0;
      do_reset();

      // single request from requester 2
      rq[2].push_back(32'd1);
      n_ack = 0; n_dval = 0;
      run_quiet(500);
      chk("single_idx", 32'(last_rsp_idx), 32'd2);
      chk("single_data", last_rsp_data, 32'h3F80_0000);
      chk("single_acks", 32'(n_ack), 32'd1);
      chk("single_dvals", 32'(n_dval), 32'd1);
      chk("single_busy_after", 32'(busy), 32'd0);

      // value coverage through requester 0
      for (int k = 0; k < 4; k++) begin
         rq[0].push_back(tv[k]);
         run_quiet(500);
         chk("vec_idx", 32'(last_rsp_idx), 32'd0);
         chk("vec_data", last_rsp_data, te[k]);
      end

      // simultaneous requests right after reset
      do_reset();
      for (int i = 0; i < NREQ; i++) rq[i].push_back($urandom);
      grant_log.delete();
      run_quiet(1000);
      chk("simul_grants", 32'(grant_log.size()), 32'd4);
      for (int k = 0; k < 4 && k < grant_log.size(); k++) chk("simul_order", 32'(grant_log[k]), 32'(k));

      // fairness: requesters 1 and 3 continuously requesting
      grant_log.delete();
      for (int k = 0; k < 3; k++) begin
         rq[1].push_back($urandom);
         rq[3].push_back($urandom);
      end
      run_quiet(1500);
      chk("fair_grants", 32'(grant_log.size()), 32'd6);
      for (int k = 0; k < 6 && k < grant_log.size(); k++)
         chk("fair_order", 32'(grant_log[k]), (k % 2 == 0) ? 32'd1 : 32'd3);

      // randomized traffic
      for (int r = 0; r < 400; r++) begin
         if ($urandom_range(7, 0) == 0) rq[$urandom_range(NREQ - 1, 0)].push_back($urandom);
         tick();
      end
      run_quiet(3000);

      // watchdog with a late rdy injected during HOLD
      conv_dead = 1'b1;
      base = n_err;
      rq[1].push_back($urandom);
      n = 0;
      while (n_err == base && n < 300) begin tick(); n++; end
      chk("wd_err_seen", 32'(n < 300), 32'd1);
      chk("wd_delay", 32'(err_cyc_obs - dval_cyc_obs), 32'(TIMEOUT + 1));
      chk("wd_data", last_rsp_data, 32'h7FC0_0000);
      chk("wd_idx", 32'(last_rsp_idx), 32'd1);
      repeat (10) tick();
      nb = n_rsp;
      inj = 1'b1;
      tick();
      tick();
      chk("wd_hold_exit", 32'(busy), 32'd0);
      chk("wd_late_dropped", 32'(n_rsp), 32'(nb));
      conv_dead = 1'b0;
      rq[2].push_back(32'd5);
      run_quiet(500);
      chk("wd_next_idx", 32'(last_rsp_idx), 32'd2);
      chk("wd_next_data", last_rsp_data, 32'h40A0_0000);
      chk("wd_err_count", 32'(n_err - base), 32'd1);

      // watchdog with HOLD expiring on its own
      conv_dead = 1'b1;
      rq[3].push_back($urandom);
      run_quiet(500);
      chk("wd2_err_count", 32'(n_err - base), 32'd2);
      chk("wd2_data", last_rsp_data, 32'h7FC0_0000);
      conv_dead = 1'b0;

      // reset three cycles after the converter start pulse
      nb = n_dval;
      rq[0].push_back(32'hFFFF_FFF9);
      n = 0;
      while (n_dval == nb && n < 100) begin tick(); n++; end
      chk("rstw_dval_seen", 32'(n < 100), 32'd1);
      repeat (3) tick();
      do_reset();
      nb = n_rsp;
      repeat (50) tick();
      chk("rstw_no_rsp", 32'(n_rsp), 32'(nb));
      rq[0].push_back(32'hFFFF_FFF9);
      run_quiet(500);
      chk("rstw_reissue_idx", 32'(last_rsp_idx), 32'd0);
      chk("rstw_reissue_data", last_rsp_data, 32'hC0E0_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
